// File: rtl/extremum_pkg.sv
// Shared types and constants for the array extremum finder.
package extremum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/extremum_compare.sv
// Combinational element comparator: decides whether the candidate replaces
// the current best, for max/min search, signed/unsigned data and either
// tie-breaking policy.
module extremum_compare
  import extremum_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] candidate,
  input  logic [W-1:0] best,
  input  logic         mode,
  input  logic         is_signed,
  input  logic         tie_last,
  output logic         take_candidate
);

  logic cand_gt;
  logic cand_lt;
  logic cand_eq;

  // One magnitude comparator; min mode just looks at the opposite direction.
  always_comb begin
    if (is_signed) begin
      cand_gt = $signed(candidate) > $signed(best);
      cand_lt = $signed(candidate) < $signed(best);
    end else begin
      cand_gt = candidate > best;
      cand_lt = candidate < best;
    end
    cand_eq = (candidate == best);
    if (mode == MODE_MIN) begin
      take_candidate = cand_lt | (cand_eq & tie_last);
    end else begin
      take_candidate = cand_gt | (cand_eq & tie_last);
    end
  end

endmodule

// File: rtl/array_extremum_finder.sv
// Scans a snapshot of N W-bit elements, one element per clock, and reports
// the index and value of the maximum or minimum element.
//
// state | meaning
// IDLE  | out of reset, waiting for the first start
// SCAN  | comparing element[cnt] against the running best
// DONE  | result valid on ext_index/ext_value, next start accepted
module array_extremum_finder
  import extremum_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int W    = 8,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              is_signed,
  input  logic              tie_last,
  input  logic [N*W-1:0]    input_array,
  output logic              busy,
  output logic              completed,
  output logic [IDXW-1:0]   ext_index,
  output logic [W-1:0]      ext_value
);

  state_e            state_q, state_d;
  logic [N*W-1:0]    snap_q, snap_d;
  logic              mode_q, mode_d;
  logic              signed_q, signed_d;
  logic              tie_q, tie_d;
  logic [IDXW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      best_val_q, best_val_d;
  logic [IDXW-1:0]   best_idx_q, best_idx_d;
  logic [IDXW-1:0]   ext_index_q, ext_index_d;
  logic [W-1:0]      ext_value_q, ext_value_d;
  logic              completed_q, completed_d;

  logic              accept;
  logic              last_elem;
  logic              take;
  logic [W-1:0]      elems [N];
  logic [W-1:0]      candidate;

  assign accept    = start && (state_q != SCAN);
  assign last_elem = (cnt_q == IDXW'(N - 1));

  // Unpack the snapshot into addressable elements.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      elems[i] = snap_q[i*W +: W];
    end
  end

  // A single-element array has no scan phase, so the counter never selects.
  generate
    if (N == 1) begin : g_single
      // Only element 0 exists.
      always_comb candidate = elems[0];
    end else begin : g_multi
      // Element under inspection this cycle.
      always_comb candidate = elems[cnt_q];
    end
  endgenerate

  extremum_compare #(.W(W)) u_compare (
    .candidate      (candidate),
    .best           (best_val_q),
    .mode           (mode_q),
    .is_signed      (signed_q),
    .tie_last       (tie_q),
    .take_candidate (take)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; start is ignored while scanning.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (N == 1) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (last_elem) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy comes only from the registered state.
  always_comb begin
    busy = (state_q == SCAN);
  end

  // Datapath next values: snapshot on accept, fold one element per SCAN cycle.
  always_comb begin
    snap_d      = snap_q;
    mode_d      = mode_q;
    signed_d    = signed_q;
    tie_d       = tie_q;
    cnt_d       = cnt_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    ext_index_d = ext_index_q;
    ext_value_d = ext_value_q;
    completed_d = completed_q;
    if (accept) begin
      snap_d      = input_array;
      mode_d      = mode;
      signed_d    = is_signed;
      tie_d       = tie_last;
      best_val_d  = input_array[W-1:0];
      best_idx_d  = '0;
      cnt_d       = IDXW'(1);
      completed_d = 1'b0;
      if (N == 1) begin
        completed_d = 1'b1;
        ext_index_d = '0;
        ext_value_d = input_array[W-1:0];
      end
    end else if (state_q == SCAN) begin
      if (take) begin
        best_val_d = candidate;
        best_idx_d = cnt_q;
      end
      cnt_d = cnt_q + IDXW'(1);
      if (last_elem) begin
        completed_d = 1'b1;
        ext_index_d = take ? cnt_q : best_idx_q;
        ext_value_d = take ? candidate : best_val_q;
      end
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q      <= '0;
      mode_q      <= 1'b0;
      signed_q    <= 1'b0;
      tie_q       <= 1'b0;
      cnt_q       <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      ext_index_q <= '0;
      ext_value_q <= '0;
      completed_q <= 1'b0;
    end else begin
      snap_q      <= snap_d;
      mode_q      <= mode_d;
      signed_q    <= signed_d;
      tie_q       <= tie_d;
      cnt_q       <= cnt_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      ext_index_q <= ext_index_d;
      ext_value_q <= ext_value_d;
      completed_q <= completed_d;
    end
  end

  assign completed = completed_q;
  assign ext_index = ext_index_q;
  assign ext_value = ext_value_q;

endmodule
